lcd_bus_decoder: RTL

- Display-side receiver for the 4-bit HD44780-style LCD bus (LCD_E, LCD_RS, SF_D) that our lcd controller drives.
- Reassembles nibbles into bytes, decodes the command subset the controller uses, and keeps a shadow DDRAM of what the panel would show.
- Shadow DDRAM has a registered read port.
- Used as an on-chip bus monitor and mirror (debug readback, HC header) and as the responder model in controller benches.

---
 rtl/lcd_bus_decoder.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_decoder.sv
// Receiver/mirror for the 4-bit HD44780-style LCD bus: synchronizes the bus, reassembles
// nibbles, decodes the command subset and keeps a shadow DDRAM with a registered read port.
module lcd_bus_decoder #(
   parameter int          E_MIN_HIGH = 2,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic       CLK12,
   input  logic       reset,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic [3:0] SF_D,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_rs,
   output logic [6:0] cursor,
   output logic       mode4,
   output logic       disp_on,
   output logic       busy,
   output logic       protocol_err
);

   typedef enum logic [1:0] {ST_INIT8, ST_HI, ST_LO, ST_CLEAR} state_t;

   localparam logic [3:0] E_MIN = 4'(E_MIN_HIGH);

   // ---------------- input capture ----------------
   logic       e_meta_q, e_sync_q, e_prev_q;
   logic       e_meta_d, e_sync_d, e_prev_d;
   logic       rs_meta_q, rs_sync_q, rs_meta_d, rs_sync_d;
   logic [3:0] d_meta_q, d_sync_q, d_meta_d, d_sync_d;
   logic [3:0] hcnt_q, hcnt_d;
   logic       strobe_q, strobe_d;
   logic [3:0] snib_q, snib_d;
   logic       srs_q, srs_d;
   logic       fall, glitch;

   always_comb begin
      e_meta_d  = LCD_E;
      e_sync_d  = e_meta_q;
      e_prev_d  = e_sync_q;
      rs_meta_d = LCD_RS;
      rs_sync_d = rs_meta_q;
      d_meta_d  = SF_D;
      d_sync_d  = d_meta_q;
      fall      = e_prev_q & ~e_sync_q;
      // hcnt_q holds the completed high time in the cycle the falling edge is seen
      if (e_sync_q)
         hcnt_d = (hcnt_q == 4'hF) ? 4'hF : hcnt_q + 4'd1;
      else
         hcnt_d = 4'd0;
      strobe_d = fall && (hcnt_q >= E_MIN);
      glitch   = fall && (hcnt_q < E_MIN);
      snib_d   = strobe_d ? d_sync_q  : snib_q;
      srs_d    = strobe_d ? rs_sync_q : srs_q;
   end

   always_ff @(posedge CLK12) begin
      if (reset) begin
         e_meta_q  <= 1'b0;
         e_sync_q  <= 1'b0;
         e_prev_q  <= 1'b0;
         rs_meta_q <= 1'b0;
         rs_sync_q <= 1'b0;
         d_meta_q  <= 4'd0;
         d_sync_q  <= 4'd0;
         hcnt_q    <= 4'd0;
         strobe_q  <= 1'b0;
         snib_q    <= 4'd0;
         srs_q     <= 1'b0;
      end else begin
         e_meta_q  <= e_meta_d;
         e_sync_q  <= e_sync_d;
         e_prev_q  <= e_prev_d;
         rs_meta_q <= rs_meta_d;
         rs_sync_q <= rs_sync_d;
         d_meta_q  <= d_meta_d;
         d_sync_q  <= d_sync_d;
         hcnt_q    <= hcnt_d;
         strobe_q  <= strobe_d;
         snib_q    <= snib_d;
         srs_q     <= srs_d;
      end
   end

   // ---------------- decoder FSM ----------------
   state_t     state_q, state_d;
   logic [3:0] hi_nib_q, hi_nib_d;
   logic       hi_rs_q, hi_rs_d;
   logic       clr_phase_q, clr_phase_d;
   logic [6:0] clr_addr_q, clr_addr_d;
   logic [6:0] cursor_q, cursor_d;
   logic       inc_q, inc_d;
   logic       mode4_q, mode4_d;
   logic       disp_on_q, disp_on_d;
   logic       perr_q, perr_d;
   logic       bv_q, bv_d;
   logic [7:0] bdata_q, bdata_d;
   logic       brs_q, brs_d;
   logic       we;
   logic [6:0] waddr;
   logic [7:0] wdata;
   logic [7:0] asm_byte;

   function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic up);
      if (up)
         cursor_step = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else
         cursor_step = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      hi_nib_d    = hi_nib_q;
      hi_rs_d     = hi_rs_q;
      clr_phase_d = clr_phase_q;
      clr_addr_d  = clr_addr_q;
      cursor_d    = cursor_q;
      inc_d       = inc_q;
      mode4_d     = mode4_q;
      disp_on_d   = disp_on_q;
      perr_d      = perr_q | glitch;
      bv_d        = 1'b0;
      bdata_d     = bdata_q;
      brs_d       = brs_q;
      asm_byte    = {hi_nib_q, snib_q};
      we          = 1'b0;
      waddr       = cursor_q;
      wdata       = asm_byte;

      case (state_q)
         ST_INIT8: begin
            if (strobe_q && !srs_q && snib_q == 4'h2) begin
               mode4_d = 1'b1;
               state_d = ST_HI;
            end
         end
         ST_HI: begin
            if (strobe_q) begin
               hi_nib_d = snib_q;
               hi_rs_d  = srs_q;
               state_d  = ST_LO;
            end
         end
         ST_LO: begin
            if (strobe_q) begin
               state_d = ST_HI;
               bv_d    = 1'b1;
               bdata_d = asm_byte;
               brs_d   = hi_rs_q;
               if (srs_q != hi_rs_q)
                  perr_d = 1'b1;
               if (hi_rs_q) begin
                  we       = 1'b1;
                  cursor_d = cursor_step(cursor_q, inc_q);
               end else begin
                  casez (asm_byte)
                     8'b1???????: cursor_d  = asm_byte[6:0];
                     8'b00001???: disp_on_d = asm_byte[2];
                     8'b000001??: inc_d     = asm_byte[1];
                     8'b0000001?: cursor_d  = 7'h00;
                     8'b00000001: begin
                        state_d     = ST_CLEAR;
                        clr_addr_d  = 7'h00;
                        clr_phase_d = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CLEAR: begin
            we         = 1'b1;
            waddr      = clr_addr_q;
            wdata      = BLANK_CHAR;
            clr_addr_d = clr_addr_q + 7'd1;
            // nibbles keep being paired so the bus stays in step, but bytes are not executed
            if (strobe_q) begin
               if (!clr_phase_q) begin
                  hi_nib_d    = snib_q;
                  hi_rs_d     = srs_q;
                  clr_phase_d = 1'b1;
               end else begin
                  clr_phase_d = 1'b0;
                  bv_d        = 1'b1;
                  bdata_d     = asm_byte;
                  brs_d       = hi_rs_q;
                  perr_d      = 1'b1;
               end
            end
            if (clr_addr_q == 7'h7F) begin
               state_d  = ST_HI;
               cursor_d = 7'h00;
               inc_d    = 1'b1;
            end
         end
         default: state_d = ST_INIT8;
      endcase
   end

   always_ff @(posedge CLK12) begin
      if (reset) begin
         state_q     <= ST_INIT8;
         hi_nib_q    <= 4'd0;
         hi_rs_q     <= 1'b0;
         clr_phase_q <= 1'b0;
         clr_addr_q  <= 7'd0;
         cursor_q    <= 7'd0;
         inc_q       <= 1'b1;
         mode4_q     <= 1'b0;
         disp_on_q   <= 1'b0;
         perr_q      <= 1'b0;
         bv_q        <= 1'b0;
         bdata_q     <= 8'd0;
         brs_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_nib_q    <= hi_nib_d;
         hi_rs_q     <= hi_rs_d;
         clr_phase_q <= clr_phase_d;
         clr_addr_q  <= clr_addr_d;
         cursor_q    <= cursor_d;
         inc_q       <= inc_d;
         mode4_q     <= mode4_d;
         disp_on_q   <= disp_on_d;
         perr_q      <= perr_d;
         bv_q        <= bv_d;
         bdata_q     <= bdata_d;
         brs_q       <= brs_d;
      end
   end

   // ---------------- shadow DDRAM (contents survive reset) ----------------
   logic [7:0] mem [128];
   logic [7:0] rd_data_q;

   always_ff @(posedge CLK12) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge CLK12) begin
      if (reset)
         rd_data_q <= 8'd0;
      else
         rd_data_q <= mem[rd_addr];
   end

   assign rd_data      = rd_data_q;
   assign byte_valid   = bv_q;
   assign byte_data    = bdata_q;
   assign byte_rs      = brs_q;
   assign cursor       = cursor_q;
   assign mode4        = mode4_q;
   assign disp_on      = disp_on_q;
   assign busy         = (state_q == ST_CLEAR);
   assign protocol_err = perr_q;

endmodule
